// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: imem request/response, IF/ID register, stall hold buffer, flush kill
module fetch_stage #(
    parameter int          SIZE = 32,
    parameter logic [31:0] NOP  = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] pc_f,
    input  logic [SIZE-1:0] pc_plus4_f,
    input  logic            flushD,
    input  logic            stallD,
    output logic            imem_req_valid,
    output logic [SIZE-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [SIZE-1:0] imem_rsp_data,
    output logic            pc_en,
    output logic [SIZE-1:0] instrD,
    output logic [SIZE-1:0] pcD,
    output logic [SIZE-1:0] pc_plus4D,
    output logic            validD
);

    localparam logic [SIZE-1:0] W_NOP = SIZE'(NOP);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_kill;
    logic            w_kill_nxt;
    logic [SIZE-1:0] r_pcq;
    logic [SIZE-1:0] r_pc4q;
    logic [SIZE-1:0] r_hold_instr;
    logic [SIZE-1:0] r_hold_pc;
    logic [SIZE-1:0] r_hold_pc4;
    logic [SIZE-1:0] r_instr_d;
    logic [SIZE-1:0] r_pc_d;
    logic [SIZE-1:0] r_pc4_d;
    logic            r_valid_d;
    logic            w_req_accept;
    logic            w_load_hold;
    logic            w_deliver_rsp;
    logic            w_deliver_hold;

    // A flush always wins: a response seen alongside it is consumed but never delivered.
    always_comb begin
        w_state_nxt    = r_state;
        w_kill_nxt     = r_kill;
        w_req_accept   = 1'b0;
        w_load_hold    = 1'b0;
        w_deliver_rsp  = 1'b0;
        w_deliver_hold = 1'b0;
        case (r_state)
            S_REQ: begin
                if (imem_req_ready) begin
                    w_req_accept = 1'b1;
                    w_state_nxt  = S_WAIT;
                    w_kill_nxt   = flushD;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (r_kill || flushD) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else if (stallD) begin
                        w_load_hold = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_deliver_rsp = 1'b1;
                        w_state_nxt   = S_REQ;
                    end
                end else if (flushD) begin
                    w_kill_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (flushD) begin
                    w_state_nxt = S_REQ;
                end else if (!stallD) begin
                    w_deliver_hold = 1'b1;
                    w_state_nxt    = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
                w_kill_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_REQ;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcq        <= '0;
            r_pc4q       <= '0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
            r_hold_pc4   <= '0;
        end else begin
            if (w_req_accept) begin
                r_pcq  <= pc_f;
                r_pc4q <= pc_plus4_f;
            end
            if (w_load_hold) begin
                r_hold_instr <= imem_rsp_data;
                r_hold_pc    <= r_pcq;
                r_hold_pc4   <= r_pc4q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr_d <= W_NOP;
            r_pc_d    <= '0;
            r_pc4_d   <= '0;
            r_valid_d <= 1'b0;
        end else if (flushD) begin
            r_instr_d <= W_NOP;
            r_pc_d    <= '0;
            r_pc4_d   <= '0;
            r_valid_d <= 1'b0;
        end else if (w_deliver_rsp) begin
            r_instr_d <= imem_rsp_data;
            r_pc_d    <= r_pcq;
            r_pc4_d   <= r_pc4q;
            r_valid_d <= 1'b1;
        end else if (w_deliver_hold) begin
            r_instr_d <= r_hold_instr;
            r_pc_d    <= r_hold_pc;
            r_pc4_d   <= r_hold_pc4;
            r_valid_d <= 1'b1;
        end
    end

    // PC only moves once its fetch has landed in IF/ID, or on a redirect.
    assign pc_en          = rst & (w_deliver_rsp | w_deliver_hold | flushD);
    assign imem_req_valid = rst & (r_state == S_REQ);
    assign imem_req_addr  = pc_f;
    assign instrD         = r_instr_d;
    assign pcD            = r_pc_d;
    assign pc_plus4D      = r_pc4_d;
    assign validD         = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f, pc_plus4_f;
    logic        flushD, stallD;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        pc_en;
    logic [31:0] instrD, pcD, pc_plus4D;
    logic        validD;

    fetch_stage #(.SIZE(32), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f),
        .flushD(flushD), .stallD(stallD),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .pc_en(pc_en),
        .instrD(instrD), .pcD(pcD), .pc_plus4D(pc_plus4D), .validD(validD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          rdy_wait;
        int          rsp_lat;
        int          stall_cyc;
        int          exp_cycles;
    } vec_t;

    logic [95:0] exp_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] last_instr = NOP;
    logic        last_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_fetch(input vec_t v);
        int          cyc;
        logic [95:0] e;
        cyc = 0;
        pc_f = v.pc; pc_plus4_f = v.pc + 32'd4;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; stallD = 1'b0; flushD = 1'b0;
        exp_q.push_back({v.data, v.pc, v.pc + 32'd4});
        for (int i = 0; i < v.rdy_wait; i++) begin
            #1;
            check("req_valid_wait", imem_req_valid, 1);
            check("req_addr_stable", imem_req_addr, v.pc);
            check("pc_en_not_ready", pc_en, 0);
            tick(); cyc++;
        end
        imem_req_ready = 1'b1;
        #1;
        check("req_valid_accept", imem_req_valid, 1);
        check("req_addr_accept", imem_req_addr, v.pc);
        check("pc_en_accept", pc_en, 0);
        tick(); cyc++;
        imem_req_ready = 1'b0;
        for (int i = 0; i < v.rsp_lat - 1; i++) begin
            #1;
            check("req_valid_in_wait", imem_req_valid, 0);
            check("pc_en_in_wait", pc_en, 0);
            check("validD_in_wait", validD, last_valid);
            tick(); cyc++;
        end
        imem_rsp_valid = 1'b1; imem_rsp_data = v.data;
        if (v.stall_cyc > 0) begin
            stallD = 1'b1;
            #1;
            check("pc_en_rsp_stalled", pc_en, 0);
            tick(); cyc++;
            imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
            for (int i = 0; i < v.stall_cyc - 1; i++) begin
                #1;
                check("pc_en_hold", pc_en, 0);
                check("instrD_hold", instrD, last_instr);
                check("validD_hold", validD, last_valid);
                check("req_valid_hold", imem_req_valid, 0);
                tick(); cyc++;
            end
            stallD = 1'b0;
        end
        #1;
        check("pc_en_deliver", pc_en, 1);
        tick(); cyc++;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        #1;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL sb_empty: got no expected entry, required one");
        end else begin
            e = exp_q.pop_front();
            check("instrD", instrD, e[95:64]);
            check("pcD", pcD, e[63:32]);
            check("pc_plus4D", pc_plus4D, e[31:0]);
        end
        check("validD_deliver", validD, 1);
        check("pc_en_pulse_end", pc_en, 0);
        check("req_valid_next", imem_req_valid, 1);
        check("fetch_cycles", cyc, v.exp_cycles);
        last_instr = v.data; last_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[5];
        vec_t v;
        tbl[0] = '{32'h0000_0000, 32'h0050_0093, 0, 1, 0, 2};
        tbl[1] = '{32'h0000_0004, 32'h0020_0193, 3, 2, 0, 6};
        tbl[2] = '{32'h0000_0008, 32'h00A0_0113, 0, 1, 4, 6};
        tbl[3] = '{32'h0000_000C, 32'h0030_0213, 0, 1, 0, 2};
        tbl[4] = '{32'h0000_0020, 32'h1234_5678, 1, 3, 2, 7};

        rst = 1'b0; pc_f = 32'h0; pc_plus4_f = 32'h4; flushD = 1'b0; stallD = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        tick();
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_pc_en", pc_en, 0);
        check("rst_validD", validD, 0);
        check("rst_instrD", instrD, NOP);
        check("rst_pcD", pcD, 0);
        check("rst_pc_plus4D", pc_plus4D, 0);
        tick();
        rst = 1'b1;

        for (int i = 0; i < 5; i++) run_fetch(tbl[i]);

        // flush while waiting on pc 0x10; late response must be dropped
        pc_f = 32'h10; pc_plus4_f = 32'h14; imem_req_ready = 1'b1;
        #1; check("flw_req_valid", imem_req_valid, 1);
        tick();
        imem_req_ready = 1'b0; flushD = 1'b1;
        #1; check("flw_pc_en", pc_en, 1);
        tick();
        flushD = 1'b0; pc_f = 32'h40; pc_plus4_f = 32'h44;
        #1;
        check("flw_validD", validD, 0);
        check("flw_instrD", instrD, NOP);
        check("flw_pcD", pcD, 0);
        check("flw_req_valid_kill", imem_req_valid, 0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        #1; check("flw_drop_pc_en", pc_en, 0);
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        check("flw_drop_instrD", instrD, NOP);
        check("flw_drop_validD", validD, 0);
        check("flw_redirect_valid", imem_req_valid, 1);
        check("flw_redirect_addr", imem_req_addr, 32'h40);
        last_instr = NOP; last_valid = 1'b0;
        v = '{32'h0000_0040, 32'h0010_0073, 0, 1, 0, 2};
        run_fetch(v);

        // flush with response and stall in the same cycle
        pc_f = 32'h44; pc_plus4_f = 32'h48; imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_F00D; stallD = 1'b1; flushD = 1'b1;
        #1; check("frs_pc_en", pc_en, 1);
        tick();
        imem_rsp_valid = 1'b0; stallD = 1'b0; flushD = 1'b0;
        #1;
        check("frs_validD", validD, 0);
        check("frs_instrD", instrD, NOP);
        check("frs_state_req", imem_req_valid, 1);
        last_instr = NOP; last_valid = 1'b0;
        v = '{32'h0000_0080, 32'h0000_0513, 0, 1, 0, 2};
        run_fetch(v);

        // asynchronous reset while holding a stalled response
        pc_f = 32'h84; pc_plus4_f = 32'h88; imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111; stallD = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        check("ar_hold_validD", validD, 1);
        check("ar_hold_instrD", instrD, 32'h0000_0513);
        check("ar_hold_req_valid", imem_req_valid, 0);
        stallD = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("ar_validD", validD, 0);
        check("ar_instrD", instrD, NOP);
        check("ar_pcD", pcD, 0);
        check("ar_pc_plus4D", pc_plus4D, 0);
        check("ar_req_valid", imem_req_valid, 0);
        check("ar_pc_en", pc_en, 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("ar_release_req_valid", imem_req_valid, 1);
        check("ar_release_validD", validD, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage between the PC/next-PC block and the decode stage.
- Issues one instruction-memory request per PC value and waits for the response.
- Captures the returned word into the IF/ID pipeline register.
- Produces the PC advance enable and handles decode stalls (one-entry hold buffer) and branch/jump flushes.

Parameters:
- SIZE, 32, width of PC and instruction words
- NOP, 32'h00000013, instruction loaded into IF/ID on reset or flush (addi x0,x0,0)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, active-low, asynchronous
- pc_f  input  SIZE  current PC from the PC register
- pc_plus4_f  input  SIZE  pc_f + 4 from the adder
- flushD  input  1  branch/jump taken (PCSE); kills the in-flight fetch and clears IF/ID
- stallD  input  1  decode cannot accept a new instruction; holds IF/ID
- imem_req_valid  output  1  request valid
- imem_req_addr  output  SIZE  request address; equals pc_f
- imem_req_ready  input  1  memory accepts request
- imem_rsp_valid  input  1  response valid; exactly one response per accepted request, at least 1 cycle after acceptance
- imem_rsp_data  input  SIZE  instruction word
- pc_en  output  1  PC register update enable
- instrD  output  SIZE  IF/ID instruction
- pcD  output  SIZE  IF/ID PC
- pc_plus4D  output  SIZE  IF/ID PC+4
- validD  output  1  IF/ID holds a live instruction

Behaviour:
- Reset (rst=0, async):
  - state=S_REQ, kill=0, hold buffer empty.
  - instrD=NOP, pcD=0, pc_plus4D=0, validD=0.
  - imem_req_valid=0 while rst=0. pc_en=0.
- States: S_REQ, S_WAIT, S_HOLD.
- S_REQ:
  - imem_req_valid=1, imem_req_addr=pc_f.
  - On imem_req_ready=1, latch pcq=pc_f and pc4q=pc_plus4_f, then go to S_WAIT.
  - If flushD=1 in the same cycle, also set kill=1.
- S_WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with kill=1: drop the response, kill<=0, go to S_REQ.
  - On imem_rsp_valid with kill=0 and stallD=0: IF/ID <= {rsp_data, pcq, pc4q}, validD<=1, go to S_REQ.
  - On imem_rsp_valid with kill=0 and stallD=1: hold buffer <= {rsp_data, pcq, pc4q}, go to S_HOLD.
- S_HOLD:
  - imem_req_valid=0.
  - When stallD=0, move the hold buffer into IF/ID, set validD=1, go to S_REQ.
- pc_en (combinational): asserted when either condition holds:
  - an instruction is written into IF/ID this cycle (from a live response or from the hold buffer), or
  - flushD=1.
  - pc_en=0 otherwise; the PC never advances past an undelivered fetch.
- flushD (highest priority, checked every cycle):
  - IF/ID <= {NOP, 0, 0} and validD<=0, regardless of stallD.
  - In S_WAIT, or S_REQ with req accepted: kill<=1.
  - In S_HOLD: discard the buffer and go to S_REQ.
  - In S_REQ without acceptance: no state change; the next request uses the redirected pc_f.
  - A response arriving in the same cycle as flushD is dropped, not delivered.
- stallD=1 without a flush: IF/ID holds all fields unchanged.
- Single outstanding request only; no new request is issued until the current response is consumed or dropped.
- Throughput:
  - With zero-wait memory (ready=1, response 1 cycle later), one instruction every 2 cycles.
  - Latency from request acceptance to IF/ID is 1 cycle after rsp_valid.
- Reset asserted mid-transaction: state, kill and buffer clear immediately. A response still in flight after release is outside this block's contract; the memory must be reset with it.
- All PC values pass through unmodified; no arithmetic in this block.

Test Plan:
- Reset release, pc_f=0x0, pc_plus4_f=0x4, ready=1, response 0x00500093 one cycle later:
  - -> imem_req_valid=1 with addr 0x0.
  - -> next cycle instrD=0x00500093, pcD=0x0, pc_plus4D=0x4, validD=1.
  - -> pc_en pulses for exactly 1 cycle.
- Memory holds ready=0 for 3 cycles, then response 2 cycles after acceptance:
  - -> imem_req_addr stable through the wait.
  - -> pc_en=0 until the delivery cycle.
  - -> validD unchanged until then.
- Response 0x00A00113 arrives while stallD=1 for 4 cycles:
  - -> IF/ID unchanged and state S_HOLD.
  - -> on the first cycle with stallD=0, instrD=0x00A00113 and pc_en=1.
- flushD=1 while in S_WAIT for pc 0x10:
  - -> validD=0 and instrD=NOP next edge, pc_en=1.
  - -> the later response 0xDEADBEEF is dropped.
  - -> the next request uses the redirected pc_f (e.g. 0x40).
- flushD=1 in the same cycle as rsp_valid with stallD=1:
  - -> response dropped, IF/ID=NOP, validD=0, state S_REQ.
- Assert rst=0 asynchronously mid-S_HOLD:
  - -> outputs return to reset values without a clock edge, validD=0, imem_req_valid=0.
